// File: rtl/image_frame_sender.sv
// Transmit framer: emits a width byte, a height byte, then width*height pixel
// bytes pulled from an upstream valid/ready stream through one output register.
//
// state  | meaning
// IDLE   | waiting for start; rejects illegal dimensions with cfg_error
// SEND_W | width byte held on data_out until the transmitter takes it
// SEND_H | height byte held on data_out until the transmitter takes it
// PIXELS | forwarding upstream pixels, one per accepted handshake
// FLUSH  | last byte draining from the output register, then frame_done
module image_frame_sender #(
    parameter int DATA_BITS  = 8,
    parameter int MAX_WIDTH  = 32,
    parameter int MAX_HEIGHT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] cfg_width,
    input  logic [DATA_BITS-1:0] cfg_height,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 cfg_error
);

    localparam int CNT_BITS = 2 * DATA_BITS;

    typedef enum logic [2:0] {
        IDLE,
        SEND_W,
        SEND_H,
        PIXELS,
        FLUSH
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] width_r;
    logic [DATA_BITS-1:0] height_r;
    logic [DATA_BITS-1:0] x_cnt;
    logic [DATA_BITS-1:0] y_cnt;
    logic [CNT_BITS-1:0]  pix_left;

    logic out_xfer;
    logic out_free;
    logic pix_take;
    logic cfg_ok;
    logic x_last;
    logic last_pix;

    assign out_xfer = valid_out && ready_out;
    assign out_free = !valid_out || ready_out;
    assign ready_in = (state == PIXELS) && out_free && (pix_left != '0);
    assign pix_take = valid_in && ready_in;
    assign busy     = (state != IDLE);
    assign cfg_ok   = (cfg_width <= DATA_BITS'(MAX_WIDTH)) &&
                      (cfg_height <= DATA_BITS'(MAX_HEIGHT));
    assign x_last   = (x_cnt == width_r - DATA_BITS'(1));
    assign last_pix = x_last && (y_cnt == height_r - DATA_BITS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            width_r    <= '0;
            height_r   <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            pix_left   <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            cfg_error  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            cfg_error  <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with frame_done belongs to the frame just closed.
                    if (start && !frame_done) begin
                        if (cfg_ok) begin
                            width_r   <= cfg_width;
                            height_r  <= cfg_height;
                            pix_left  <= CNT_BITS'(cfg_width) * CNT_BITS'(cfg_height);
                            x_cnt     <= '0;
                            y_cnt     <= '0;
                            data_out  <= cfg_width;
                            valid_out <= 1'b1;
                            state     <= SEND_W;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end
                SEND_W: begin
                    if (out_xfer) begin
                        data_out <= height_r;
                        state    <= SEND_H;
                    end
                end
                SEND_H: begin
                    if (out_xfer) begin
                        valid_out <= 1'b0;
                        state     <= (pix_left == '0) ? FLUSH : PIXELS;
                    end
                end
                PIXELS: begin
                    if (out_xfer) begin
                        valid_out <= 1'b0;
                    end
                    if (pix_take) begin
                        data_out  <= data_in;
                        valid_out <= 1'b1;
                        pix_left  <= pix_left - CNT_BITS'(1);
                        if (x_last) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + DATA_BITS'(1);
                        end else begin
                            x_cnt <= x_cnt + DATA_BITS'(1);
                        end
                        if (last_pix) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        valid_out  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_sender.sv
// Directed bench for image_frame_sender: table of frame scenarios plus a
// mid-frame reset sequence.
module tb_image_frame_sender;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_width = '0;
    logic [7:0] cfg_height = '0;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_out = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       cfg_error;

    int n_pass = 0;
    int n_total = 0;

    image_frame_sender #(.DATA_BITS(8), .MAX_WIDTH(32), .MAX_HEIGHT(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_error  (cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] w;
        logic [7:0] h;
        logic [3:0] rpat;      // ready_out per cycle, bit (cycle % 4)
        int         start2;    // cycle of an extra 2x2 start, 0 = none
        int         nbytes;
        int         b0;
        int         b1;
        int         done;
        int         err;
        int         rdy_seen;
        int         done_gap;  // cycles from last transfer to frame_done
    } vec_t;

    function automatic vec_t mkv(input string n, input int w, input int h,
                                 input logic [3:0] rp, input int s2, input int nb,
                                 input int b0, input int b1, input int dn,
                                 input int er, input int rs, input int gap);
        vec_t v;
        v.name = n; v.w = 8'(w); v.h = 8'(h); v.rpat = rp; v.start2 = s2;
        v.nbytes = nb; v.b0 = b0; v.b1 = b1; v.done = dn; v.err = er;
        v.rdy_seen = rs; v.done_gap = gap;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int   acc = 0;
        int   done_cnt = 0;
        int   err_cnt = 0;
        int   err_cyc = -1;
        int   first_v = -1;
        int   last_x = -1;
        int   done_cyc = -1;
        int   busy_gap = 0;
        int   busy_seen = 0;
        int   busy_at_done = 1;
        int   rdy_seen = 0;
        int   budget;
        int   exp_b;
        bit   legal;
        bit   pv = 1'b0;
        bit   pr = 1'b0;
        logic [7:0] pd = '0;
        logic [7:0] q[$];

        legal  = (v.err == 0);
        budget = legal ? 4 * v.nbytes + 20 : 8;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk); #1;
            start      = (cyc == 0) || (v.start2 != 0 && cyc == v.start2);
            cfg_width  = (cyc == 0) ? v.w : 8'd2;
            cfg_height = (cyc == 0) ? v.h : 8'd2;
            ready_out  = v.rpat[cyc % 4];
            valid_in   = 1'b1;
            data_in    = 8'(8'h40 + acc);
            @(negedge clk);
            if (pv && !pr) begin
                chk({v.name, "/stall_valid"}, int'(valid_out), 1);
                chk({v.name, "/stall_data"}, int'(data_out), int'(pd));
            end
            if (valid_out && ready_out) begin
                q.push_back(data_out);
                last_x = cyc;
            end
            if (valid_out && first_v < 0) first_v = cyc;
            if (valid_in && ready_in) acc++;
            if (ready_in) rdy_seen = 1;
            if (busy) busy_seen = 1;
            if (cfg_error) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            pv = valid_out; pr = ready_out; pd = data_out;
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = int'(busy);
                break;
            end
            if (legal && cyc > 0 && !busy) busy_gap++;
        end

        // Nothing further may start: any start still pending must be ignored.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
            @(negedge clk);
            chk({v.name, "/idle_valid"}, int'(valid_out), 0);
            chk({v.name, "/idle_busy"}, int'(busy), 0);
            if (cfg_error) err_cnt++;
        end

        chk({v.name, "/nbytes"}, q.size(), v.nbytes);
        for (int i = 0; i < q.size() && i < v.nbytes; i++) begin
            exp_b = (i == 0) ? v.b0 : (i == 1) ? v.b1 : (64 + i - 2) % 256;
            chk($sformatf("%s/byte%0d", v.name, i), int'(q[i]), exp_b);
        end
        chk({v.name, "/consumed"}, acc, legal ? int'(v.w) * int'(v.h) : 0);
        chk({v.name, "/frame_done"}, done_cnt, v.done);
        chk({v.name, "/cfg_error"}, err_cnt, v.err);
        chk({v.name, "/ready_in_seen"}, rdy_seen, v.rdy_seen);
        if (legal) begin
            chk({v.name, "/first_valid_cyc"}, first_v, 1);
            chk({v.name, "/done_gap"}, done_cyc - last_x, v.done_gap);
            chk({v.name, "/busy_gap"}, busy_gap, 0);
            chk({v.name, "/busy_at_done"}, busy_at_done, 0);
        end else begin
            chk({v.name, "/err_cyc"}, err_cyc, 1);
            chk({v.name, "/busy_seen"}, busy_seen, 0);
        end
    endtask

    task automatic reset_mid_frame();
        int acc = 0;
        int done_cnt = 0;
        for (int cyc = 0; cyc < 40 && acc < 5; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 0); cfg_width = 8'd4; cfg_height = 8'd3;
            ready_out = 1'b1; valid_in = 1'b1; data_in = 8'(8'h40 + acc);
            @(negedge clk);
            if (valid_in && ready_in) acc++;
            if (frame_done) done_cnt++;
        end
        chk("rst/pre_accepted", acc, 5);
        chk("rst/pre_done", done_cnt, 0);
        @(posedge clk); #2;
        start = 1'b0;
        chk("rst/busy_before", int'(busy), 1);
        chk("rst/valid_before", int'(valid_out), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst/valid_async", int'(valid_out), 0);
        chk("rst/ready_in_async", int'(ready_in), 0);
        chk("rst/busy_async", int'(busy), 0);
        chk("rst/data_async", int'(data_out), 0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        chk("rst/done_after", int'(frame_done), 0);
        chk("rst/valid_after", int'(valid_out), 0);
        run_vec(mkv("after_rst_2x1", 2, 1, 4'b1111, 0, 4, 2, 1, 1, 0, 1, 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        vecs[0]  = mkv("f4x3",       4,  3,  4'b1111, 0, 14,   4,  3,  1, 0, 1, 1);
        vecs[1]  = mkv("f4x3_stall", 4,  3,  4'b1001, 0, 14,   4,  3,  1, 0, 1, 1);
        vecs[2]  = mkv("w0h5",       0,  5,  4'b1111, 0, 2,    0,  5,  1, 0, 0, 2);
        vecs[3]  = mkv("w33",        33, 1,  4'b1111, 0, 0,    0,  0,  0, 1, 0, 0);
        vecs[4]  = mkv("f2x2",       2,  2,  4'b1111, 0, 6,    2,  2,  1, 0, 1, 1);
        vecs[5]  = mkv("f4x3_2nd",   4,  3,  4'b1111, 6, 14,   4,  3,  1, 0, 1, 1);
        vecs[6]  = mkv("h33",        1,  33, 4'b1111, 0, 0,    0,  0,  0, 1, 0, 0);
        vecs[7]  = mkv("w0h0",       0,  0,  4'b1111, 0, 2,    0,  0,  1, 0, 0, 2);
        vecs[8]  = mkv("f32x32",     32, 32, 4'b1111, 0, 1026, 32, 32, 1, 0, 1, 1);
        vecs[9]  = mkv("f5x1_stall", 5,  1,  4'b0110, 0, 7,    5,  1,  1, 0, 1, 1);
        vecs[10] = mkv("done_start", 2,  1,  4'b1111, 6, 4,    2,  1,  1, 0, 1, 1);

        #3;
        chk("reset/data_out", int'(data_out), 0);
        chk("reset/valid_out", int'(valid_out), 0);
        chk("reset/ready_in", int'(ready_in), 0);
        chk("reset/busy", int'(busy), 0);
        chk("reset/frame_done", int'(frame_done), 0);
        chk("reset/cfg_error", int'(cfg_error), 0);
        #20 rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);
        reset_mid_frame();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
